// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: function codes, FSM encoding and
// response class encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] FUN_ADD    = 4'b0000;
  localparam logic [3:0] FUN_SUB    = 4'b0001;
  localparam logic [3:0] FUN_MUL    = 4'b0010;
  localparam logic [3:0] FUN_DIV    = 4'b0011;
  localparam logic [3:0] FUN_AND    = 4'b0100;
  localparam logic [3:0] FUN_OR     = 4'b0101;
  localparam logic [3:0] FUN_XOR    = 4'b0110;
  localparam logic [3:0] FUN_NOT    = 4'b0111;
  localparam logic [3:0] FUN_CMP_EQ = 4'b1000;
  localparam logic [3:0] FUN_CMP_NE = 4'b1001;
  localparam logic [3:0] FUN_CMP_LT = 4'b1010;
  localparam logic [3:0] FUN_CMP_GT = 4'b1011;
  localparam logic [3:0] FUN_SHL    = 4'b1100;
  localparam logic [3:0] FUN_SHR    = 4'b1101;
  localparam logic [3:0] FUN_ROL    = 4'b1110;
  localparam logic [3:0] FUN_NOP    = 4'b1111;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_LOGIC = 2'd1,
    CLS_CMP   = 2'd2,
    CLS_SHIFT = 2'd3
  } rsp_class_t;

  function automatic logic is_div_zero(input logic [3:0] fun, input logic b_zero);
    return (fun == FUN_DIV) && b_zero;
  endfunction

  // Flags are one-hot; with none set the class falls back to arith.
  function automatic rsp_class_t class_of(input logic arith, input logic lgc,
                                          input logic cmp, input logic shift);
    rsp_class_t c;
    c = CLS_ARITH;
    if (shift)      c = CLS_SHIFT;
    else if (cmp)   c = CLS_CMP;
    else if (lgc)   c = CLS_LOGIC;
    else if (arith) c = CLS_ARITH;
    return c;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two request channels and two
// response channels sharing one data/class/err return path.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             REQ0_VALID;
  logic             REQ0_READY;
  logic [WIDTH-1:0] REQ0_A;
  logic [WIDTH-1:0] REQ0_B;
  logic [3:0]       REQ0_FUN;
  logic             REQ1_VALID;
  logic             REQ1_READY;
  logic [WIDTH-1:0] REQ1_A;
  logic [WIDTH-1:0] REQ1_B;
  logic [3:0]       REQ1_FUN;
  logic             RSP0_VALID;
  logic             RSP0_READY;
  logic             RSP1_VALID;
  logic             RSP1_READY;
  logic [WIDTH-1:0] RSP_DATA;
  logic [1:0]       RSP_CLASS;
  logic             RSP_ERR;

  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    output RSP0_READY, RSP1_READY,
    input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID,
    input  RSP_DATA, RSP_CLASS, RSP_ERR
  );

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    input  RSP0_READY, RSP1_READY,
    output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID,
    output RSP_DATA, RSP_CLASS, RSP_ERR
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Grants are combinational while enabled;
// last_grant records the owner of the most recent accept.
module rr_arbiter2 (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1,
  output logic accept,
  output logic last_grant
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  assign accept = grant0 | grant1;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared registered ALU: accepts one op,
// runs it through the ALU's one-cycle latency and returns the result.
//
//   state   | meaning
//   IDLE    | waiting for a request; grant winner sees READY
//   ISSUE   | ALU inputs driven from the accepted op
//   CAPTURE | ALU_OUT and class flags valid; sampled at the edge
//   RESPOND | owner's RSP_VALID high until its RSP_READY
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int         WIDTH   = ALU_WIDTH,
  parameter logic [3:0] NOP_FUN = FUN_NOP
) (
  input  logic             CLK,
  input  logic             RST,
  alu_arbiter_if.slave     bus,
  output logic             BUSY,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ARITH_FLAG,
  input  logic             LOGIC_FLAG,
  input  logic             CMP_FLAG,
  input  logic             SHIFT_FLAG
);

  logic [1:0]       state;
  logic             grant0, grant1, accept, owner;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  rsp_class_t       rsp_class;
  logic             rsp_err;
  logic [WIDTH-1:0] acc_a, acc_b;
  logic [3:0]       acc_fun;
  logic             div_zero, owner_ready, any_flag;

  // The arbiter's last_grant doubles as the owner of the op in flight.
  rr_arbiter2 u_arb (
    .CLK        (CLK),
    .RST        (RST),
    .en         (state == S_IDLE),
    .valid0     (bus.REQ0_VALID),
    .valid1     (bus.REQ1_VALID),
    .grant0     (grant0),
    .grant1     (grant1),
    .accept     (accept),
    .last_grant (owner)
  );

  assign acc_a       = grant1 ? bus.REQ1_A   : bus.REQ0_A;
  assign acc_b       = grant1 ? bus.REQ1_B   : bus.REQ0_B;
  assign acc_fun     = grant1 ? bus.REQ1_FUN : bus.REQ0_FUN;
  assign div_zero    = is_div_zero(acc_fun, acc_b == '0);
  assign owner_ready = owner ? bus.RSP1_READY : bus.RSP0_READY;
  assign any_flag    = ARITH_FLAG | LOGIC_FLAG | CMP_FLAG | SHIFT_FLAG;

  assign bus.REQ0_READY = grant0;
  assign bus.REQ1_READY = grant1;
  assign bus.RSP0_VALID = rsp_valid[0];
  assign bus.RSP1_VALID = rsp_valid[1];
  assign bus.RSP_DATA   = rsp_data;
  assign bus.RSP_CLASS  = rsp_class;
  assign bus.RSP_ERR    = rsp_err;
  assign BUSY           = (state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_class <= CLS_ARITH;
      rsp_err   <= 1'b0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= NOP_FUN;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (div_zero) begin
              // Never reaches the ALU; answered directly as an error.
              rsp_data  <= '0;
              rsp_class <= CLS_ARITH;
              rsp_err   <= 1'b1;
              rsp_valid <= grant1 ? 2'b10 : 2'b01;
              state     <= S_RESPOND;
            end else begin
              ALU_A   <= acc_a;
              ALU_B   <= acc_b;
              ALU_FUN <= acc_fun;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_CAPTURE;
        S_CAPTURE: begin
          rsp_data  <= ALU_OUT;
          rsp_class <= class_of(ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG);
          rsp_err   <= !any_flag;
          ALU_FUN   <= NOP_FUN;
          rsp_valid <= owner ? 2'b10 : 2'b01;
          state     <= S_RESPOND;
        end
        S_RESPOND: begin
          if (owner_ready) begin
            rsp_valid <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
